// File: rtl/phy_wb_pkg.sv
// ---------------------------------------------------------------------------
// phy_wb_pkg
// Shared constants and types for the PHY-side Wishbone frame sink.
//   FRAME_LEN : nibbles per frame
//   DW        : width of one Wishbone beat
//   AW        : width of the write/read frame address counters
//   state_t   : frame sink control states
// ---------------------------------------------------------------------------
package phy_wb_pkg;

    localparam int FRAME_LEN = 104;
    localparam int DW        = 4;
    localparam int AW        = 7;

    // Address of the final nibble in a frame; terminates both write and read.
    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        RECV  = 2'd0,
        FULL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/wb_frame_sink_if.sv
// ---------------------------------------------------------------------------
// wb_frame_sink_if
// Write-only Wishbone link between the PHY transmit master and the frame sink.
//   DAT_I : beat data (master -> slave)
//   CYC_I : bus cycle valid (master -> slave)
//   STB_I : strobe (master -> slave)
//   WE_I  : write enable (master -> slave)
//   ACK_O : beat acknowledge (slave -> master)
// ---------------------------------------------------------------------------
interface wb_frame_sink_if;
    import phy_wb_pkg::*;

    logic [DW-1:0] DAT_I;
    logic          CYC_I;
    logic          STB_I;
    logic          WE_I;
    logic          ACK_O;

    modport master (
        output DAT_I,
        output CYC_I,
        output STB_I,
        output WE_I,
        input  ACK_O
    );

    modport slave (
        input  DAT_I,
        input  CYC_I,
        input  STB_I,
        input  WE_I,
        output ACK_O
    );

endinterface

// File: rtl/frame_ram.sv
// ---------------------------------------------------------------------------
// frame_ram
// Simple dual-port frame buffer: one synchronous write port, one synchronous
// read port with one cycle of latency. The read register only updates on a
// read, so the last nibble read is held between reads.
//   clk   : clock
//   srst  : synchronous reset, clears the read register only
//   we    : write enable, waddr/wdata : write address/data
//   re    : read enable,  raddr       : read address
//   rdata : registered read data
// ---------------------------------------------------------------------------
module frame_ram #(
    parameter int DEPTH = 104,
    parameter int W     = 4,
    parameter int A     = 7
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         we,
    input  logic [A-1:0] waddr,
    input  logic [W-1:0] wdata,
    input  logic         re,
    input  logic [A-1:0] raddr,
    output logic [W-1:0] rdata
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_reg;

    // Storage itself is never reset; its contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register is resettable so the read port starts at zero.
    always_ff @(posedge clk) begin
        if (srst) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/wb_frame_sink.sv
// ---------------------------------------------------------------------------
// wb_frame_sink
// Wishbone write slave that captures one FRAME_LEN-nibble frame from the PHY
// master, acknowledges every accepted beat, then hands the whole frame to a
// downstream consumer through a simple read port.
//   cl05        : clock, rising edge
//   RST_Ii      : synchronous active-high reset
//   wb          : Wishbone slave (DAT_I/CYC_I/STB_I/WE_I in, ACK_O out)
//   rd_en       : consumer requests next nibble
//   rd_data     : nibble read out, one cycle after rd_en, held otherwise
//   rd_valid    : rd_data valid strobe
//   frame_rdy   : a complete frame is held and readable
//   frame_abort : one-cycle pulse, partial frame discarded
//   overrun     : sticky, a write beat was offered while a frame was held
//   frame_cnt   : completed frames received, wraps
// ---------------------------------------------------------------------------
module wb_frame_sink
    import phy_wb_pkg::*;
(
    input  logic           cl05,
    input  logic           RST_Ii,
    wb_frame_sink_if.slave wb,
    input  logic           rd_en,
    output logic [DW-1:0]  rd_data,
    output logic           rd_valid,
    output logic           frame_rdy,
    output logic           frame_abort,
    output logic           overrun,
    output logic [7:0]     frame_cnt
);

    state_t        state_reg, state_next;
    logic [AW-1:0] wcnt_reg, wcnt_next;
    logic [AW-1:0] rcnt_reg, rcnt_next;
    logic          ack_reg, ack_next;
    logic          abort_reg, abort_next;
    logic          overrun_reg, overrun_next;
    logic          rd_valid_reg, rd_valid_next;
    logic [7:0]    frame_cnt_reg, frame_cnt_next;

    logic          beat;
    logic          ram_we;
    logic          ram_re;
    logic [AW-1:0] ram_raddr;

    // A write beat is offered; master does not wait for ACK_O.
    assign beat = wb.CYC_I & wb.STB_I & wb.WE_I;

    always_ff @(posedge cl05) begin
        if (RST_Ii) begin
            state_reg     <= RECV;
            wcnt_reg      <= '0;
            rcnt_reg      <= '0;
            ack_reg       <= 1'b0;
            abort_reg     <= 1'b0;
            overrun_reg   <= 1'b0;
            rd_valid_reg  <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            wcnt_reg      <= wcnt_next;
            rcnt_reg      <= rcnt_next;
            ack_reg       <= ack_next;
            abort_reg     <= abort_next;
            overrun_reg   <= overrun_next;
            rd_valid_reg  <= rd_valid_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        wcnt_next      = wcnt_reg;
        rcnt_next      = rcnt_reg;
        ack_next       = 1'b0;
        abort_next     = 1'b0;
        overrun_next   = overrun_reg;
        frame_cnt_next = frame_cnt_reg;
        ram_we         = 1'b0;
        ram_re         = 1'b0;
        ram_raddr      = rcnt_reg;

        case (state_reg)
            RECV: begin
                if (beat) begin
                    ram_we   = 1'b1;
                    ack_next = 1'b1;
                    if (wcnt_reg == LAST_ADDR) begin
                        wcnt_next      = '0;
                        frame_cnt_next = frame_cnt_reg + 8'd1;
                        state_next     = FULL;
                    end else begin
                        wcnt_next = wcnt_reg + AW'(1);
                    end
                end else if (!wb.CYC_I && (wcnt_reg != '0)) begin
                    // Master dropped the cycle mid-frame: discard the partial frame.
                    wcnt_next  = '0;
                    abort_next = 1'b1;
                end
            end

            FULL: begin
                if (beat) begin
                    overrun_next = 1'b1;
                end
                // The first read is issued here so the drain runs back-to-back.
                if (rd_en) begin
                    ram_re     = 1'b1;
                    ram_raddr  = '0;
                    rcnt_next  = AW'(1);
                    state_next = DRAIN;
                end
            end

            DRAIN: begin
                if (beat) begin
                    overrun_next = 1'b1;
                end
                if (rd_en) begin
                    ram_re = 1'b1;
                    if (rcnt_reg == LAST_ADDR) begin
                        rcnt_next  = '0;
                        state_next = RECV;
                    end else begin
                        rcnt_next = rcnt_reg + AW'(1);
                    end
                end
            end

            default: begin
                state_next = RECV;
            end
        endcase

        rd_valid_next = ram_re;
    end

    frame_ram #(
        .DEPTH (FRAME_LEN),
        .W     (DW),
        .A     (AW)
    ) u_frame_ram (
        .clk   (cl05),
        .srst  (RST_Ii),
        .we    (ram_we),
        .waddr (wcnt_reg),
        .wdata (wb.DAT_I),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (rd_data)
    );

    assign wb.ACK_O    = ack_reg;
    assign rd_valid    = rd_valid_reg;
    assign frame_rdy   = (state_reg == FULL) || (state_reg == DRAIN);
    assign frame_abort = abort_reg;
    assign overrun     = overrun_reg;
    assign frame_cnt   = frame_cnt_reg;

endmodule

// File: doc/wb_frame_sink.md
# wb_frame_sink

Wishbone write-slave that terminates the 4-bit PHY data stream produced by `Top` (DAT_O/CYC_O/STB_O/WE_O). It captures one frame of FRAME_LEN nibbles into local storage, acknowledges each accepted beat, and then releases the complete frame to a downstream consumer through a simple read port. It sits between the PHY transmit datapath and the MAC/bit-error counter logic.

## Interface
- FRAME_LEN, 104, nibbles per frame
- DW, 4, data width of one beat
- AW, 7, address/counter width (ceil(log2(FRAME_LEN)))
- cl05  in  1  system clock; all logic on rising edge
- RST_Ii  in  1  reset, synchronous, active-high
- DAT_I  in  DW  write data from the PHY master
- CYC_I  in  1  bus cycle valid
- STB_I  in  1  strobe
- WE_I  in  1  write enable; reads (WE_I=0) are never accepted
- ACK_O  out  1  acknowledge, one per accepted beat
- rd_en  in  1  consumer requests next nibble
- rd_data  out  DW  nibble read out
- rd_valid  out  1  rd_data valid
- frame_rdy  out  1  complete frame held, readable
- frame_abort  out  1  one-cycle pulse: partial frame discarded
- overrun  out  1  sticky: beat offered while frame not drained
- frame_cnt  out  8  completed frames received, wraps 255→0

## Operation
- States: RECV, FULL, DRAIN.
- RECV: beat accepted when CYC_I&STB_I&WE_I; DAT_I written at address wcnt; wcnt++. Accepting beat FRAME_LEN-1 → wcnt=0, frame_cnt++, state FULL.
- Beats are accepted back-to-back, one per cycle; master does not wait for ACK_O.
- CYC_I low while RECV with wcnt≠0 → wcnt=0, frame_abort pulse, no frame_cnt change. CYC_I low with wcnt=0 → no action.
- FULL: frame_rdy=1. First rd_en → state DRAIN, read address rcnt=0 issued.
- DRAIN: each rd_en reads address rcnt, rcnt++. Read of address FRAME_LEN-1 → rcnt=0, state RECV next cycle. rd_en with no frame (RECV) ignored, rd_valid stays 0.
- FULL/DRAIN: write beats are not accepted, ACK_O=0, data dropped, overrun set. overrun cleared only by reset.
- WE_I=0 beats: never acked, no state effect, no overrun.
- Reset mid-operation: buffer contents are don't-care; all counters, flags, and state are reinitialised; the partial or held frame is lost, with no abort pulse.

## Timing
- Reset values: ACK_O=0, rd_data=0, rd_valid=0, frame_rdy=0, frame_abort=0, overrun=0, frame_cnt=0; state RECV, wcnt=rcnt=0.
- ACK_O registered: high in cycle N+1 for a beat accepted in cycle N.
- frame_rdy rises the cycle after the last beat is accepted, together with the last ACK_O. It falls the cycle after the final read is issued.
- Read latency 1: rd_en in cycle N → rd_data/rd_valid in N+1; rd_valid=0 otherwise; rd_data holds its last value.
- First beat accepted in the first RECV cycle after the final read, i.e. 1 cycle of no-accept after the last rd_en.
- frame_abort is registered: pulse in the cycle after CYC_I is sampled low.

## Structure
- Shared package phy_wb_pkg: FRAME_LEN, DW, AW, and the state encoding (RECV=2'd0, FULL=2'd1, DRAIN=2'd2).
- Sub-module frame_ram: simple dual-port RAM, FRAME_LEN×DW; one synchronous write port; one synchronous read port with 1-cycle latency.
- Top level holds the FSM, counters, ACK register, and flags.

## Test plan
- Reset, then 104 consecutive beats with DAT_I=i[3:0] → 104 ACK_O pulses each lagging 1 cycle; frame_rdy=1; frame_cnt=1.
- Frame held, then 104 rd_en pulses → rd_data sequence 0,1,…,F repeating, each 1 cycle after rd_en; frame_rdy=0 afterwards; state RECV.
- 50 beats, then CYC_I low for 1 cycle → frame_abort pulse; a following 104-beat frame is captured correctly from address 0.
- Frame held and 10 more beats offered → no ACK_O; overrun=1 and stays 1; held data unchanged on readout.
- 256 full write/drain cycles → frame_cnt wraps to 0.
- RST_Ii asserted during beat 60 → all outputs at reset values next cycle; the next full frame is received with frame_cnt=1.
